// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, start-glitch filtering,
// stop-bit error pulse and a valid/ready holding register that never
// overwrites unread data (a dropped good frame sets a sticky overrun flag).
// DATA_BITS must be at least 2; BAUD_DIV must be at least 2.
module uart_rx #(
   parameter int BAUD_DIV  = 163,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int NW = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic                 rx_meta;
   logic                 rxs;
   logic [CW-1:0]        baud_cnt;
   logic                 tick;

   state_t               state_q, state_d;
   logic [3:0]           s_q, s_d;
   logic [NW-1:0]        n_q, n_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 done;
   logic                 ferr;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // pre-edge value of its neighbour; blocking here would collapse the chain.
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // Free-running oversample tick generator, one tick every BAUD_DIV clocks.
   assign tick = (baud_cnt == CW'(BAUD_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
      end
   end

   // Next-state logic: mid-start check, mid-bit sampling, mid-stop check.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave a signal unassigned and infer a latch.
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      done    = 1'b0;
      ferr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == 4'd7) begin
                  if (!rxs) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     // Line went back high before mid-start: treat as noise.
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == 4'd15) begin
                  sh_d = {rxs, sh_q[DATA_BITS-1:1]};
                  s_d  = '0;
                  n_d  = n_q + NW'(1);
                  if (n_q == NW'(DATA_BITS - 1)) begin
                     state_d = STOP;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_q == 4'd15) begin
                  // Returning at mid-stop lets a back-to-back start be caught.
                  state_d = IDLE;
                  if (rxs) begin
                     done = 1'b1;
                  end else begin
                     ferr = 1'b1;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register, valid/ready handshake, error and overrun flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               // Either empty, or the old byte leaves this same cycle.
               rx_data  <= sh_q;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with BAUD_DIV=4
// (64 clocks per bit). Inputs change 1 ns after a rising edge; a negedge
// monitor records handshakes, valid edges and frame_err pulses.
module tb_uart_rx;

   localparam int BAUD_DIV  = 4;
   localparam int DATA_BITS = 8;
   localparam int BIT_CLKS  = BAUD_DIV * 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 rx;
   logic                 rx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 overrun;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int frame_start_cyc = 0;
   int ref_lat = 0;
   int ref_phase = 0;

   int valid_rises = 0;
   int valid_falls = 0;
   int ferr_pulses = 0;
   int ferr_cycles = 0;
   int last_rise_cyc = 0;
   logic prev_valid = 1'b0;
   logic prev_ferr = 1'b0;
   logic [DATA_BITS-1:0] acc_q[$];

   uart_rx #(
      .BAUD_DIV (BAUD_DIV),
      .DATA_BITS(DATA_BITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled mid-cycle when inputs and outputs are stable.
   always @(negedge clk) begin
      if (rx_valid && !prev_valid) begin
         valid_rises++;
         last_rise_cyc = cyc;
      end
      if (!rx_valid && prev_valid) valid_falls++;
      if (frame_err) ferr_cycles++;
      if (frame_err && !prev_ferr) ferr_pulses++;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      prev_valid = rx_valid;
      prev_ferr  = frame_err;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
      rx = 1'b0;
      frame_start_cyc = cyc;
      step(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         step(BIT_CLKS);
      end
      rx = stop_val;
      step(stop_len);
      rx = 1'b1;
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(5);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      reset = 1'b0;
      step(10);
   endtask

   task automatic test_good_frame();
      int rises0, fp0, lat;
      rx_ready = 1'b0;
      rises0 = valid_rises;
      fp0 = ferr_pulses;
      send_frame(8'hA5, 1'b1, BIT_CLKS);
      step(20);
      lat = last_rise_cyc - frame_start_cyc;
      ref_lat = lat;
      ref_phase = frame_start_cyc % BAUD_DIV;
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL good_data: got %h want a5", rx_data); end
      checks++; if (valid_rises - rises0 != 1) begin errors++; $display("FAIL good_rises: got %0d want 1", valid_rises - rises0); end
      checks++; if (lat < 605 || lat > 616) begin errors++; $display("FAIL good_latency: got %0d want 605..616", lat); end
      checks++; if (ferr_pulses != fp0) begin errors++; $display("FAIL good_ferr: got %0d pulses want 0", ferr_pulses - fp0); end
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL good_consume: got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL good_retain: got %h want a5", rx_data); end
   endtask

   task automatic test_start_glitch();
      int rises0, fp0;
      rises0 = valid_rises;
      fp0 = ferr_pulses;
      rx = 1'b0;
      step(12);
      rx = 1'b1;
      step(200);
      checks++; if (valid_rises != rises0) begin errors++; $display("FAIL glitch_valid: got %0d rises want 0", valid_rises - rises0); end
      checks++; if (ferr_pulses != fp0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_pulses - fp0); end
      send_frame(8'h5A, 1'b1, BIT_CLKS);
      step(20);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL glitch_next_valid: got %b want 1", rx_valid); end
      checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data: got %h want 5a", rx_data); end
      checks++; if (valid_rises - rises0 != 1) begin errors++; $display("FAIL glitch_next_rises: got %0d want 1", valid_rises - rises0); end
      drain();
   endtask

   task automatic test_bad_stop();
      int rises0, fp0, fc0;
      rises0 = valid_rises;
      fp0 = ferr_pulses;
      fc0 = ferr_cycles;
      // Stop bit low through its midpoint, then released so no new frame starts.
      send_frame(8'h3C, 1'b0, 48);
      step(BIT_CLKS * 2);
      checks++; if (ferr_pulses - fp0 != 1) begin errors++; $display("FAIL badstop_pulses: got %0d want 1", ferr_pulses - fp0); end
      checks++; if (ferr_cycles - fc0 != 1) begin errors++; $display("FAIL badstop_width: got %0d cycles want 1", ferr_cycles - fc0); end
      checks++; if (valid_rises != rises0 || rx_valid !== 1'b0) begin errors++; $display("FAIL badstop_valid: got %b want 0", rx_valid); end
      checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL badstop_data: got %h want 5a", rx_data); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL badstop_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_overrun();
      int falls0, target;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, BIT_CLKS);
      send_frame(8'h22, 1'b1, BIT_CLKS);
      step(20);
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      // Align to the tick phase of the reference frame so the ready pulse
      // lands on the very edge where 0x33 completes.
      for (int i = 0; i < BAUD_DIV && (cyc % BAUD_DIV) != ref_phase; i++) step(1);
      acc_q.delete();
      falls0 = valid_falls;
      target = ref_lat;
      fork
         send_frame(8'h33, 1'b1, BIT_CLKS);
         begin
            step(target - 1);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
         end
      join
      step(20);
      checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL ovr_sim_data: got %h want 33", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_sim_valid: got %b want 1", rx_valid); end
      checks++; if (valid_falls != falls0) begin errors++; $display("FAIL ovr_sim_nodrop: got %0d falls want 0", valid_falls - falls0); end
      checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL ovr_sim_xfers: got %0d want 1", acc_q.size()); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_reset_midframe();
      int rises0, fp0;
      rx_ready = 1'b0;
      rx = 1'b0;
      step(BIT_CLKS);
      rx = 1'b1;
      step(BIT_CLKS * 4 + BIT_CLKS / 2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
      rises0 = valid_rises;
      fp0 = ferr_pulses;
      step(BIT_CLKS * 5);
      checks++; if (valid_rises != rises0 || ferr_pulses != fp0) begin errors++; $display("FAIL midrst_flags: got %0d rises %0d ferr want 0 0", valid_rises - rises0, ferr_pulses - fp0); end
      send_frame(8'h81, 1'b1, BIT_CLKS);
      step(20);
      checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL midrst_next_data: got %h want 81", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_next_valid: got %b want 1", rx_valid); end
      checks++; if (ferr_pulses != fp0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_next_flags: got ferr %0d ovr %b want 0 0", ferr_pulses - fp0, overrun); end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      logic [7:0] got;
      int rises0, fp0;
      exp_b[0] = 8'h00;
      exp_b[1] = 8'hFF;
      exp_b[2] = 8'h55;
      acc_q.delete();
      rises0 = valid_rises;
      fp0 = ferr_pulses;
      rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, BIT_CLKS);
      step(100);
      rx_ready = 1'b0;
      checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", acc_q.size()); end
      checks++; if (valid_rises - rises0 != 3) begin errors++; $display("FAIL b2b_rises: got %0d want 3", valid_rises - rises0); end
      for (int i = 0; i < 3; i++) begin
         got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
         checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, got, exp_b[i]); end
      end
      checks++; if (ferr_pulses != fp0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_flags: got ferr %0d ovr %b want 0 0", ferr_pulses - fp0, overrun); end
   endtask

   initial begin
      reset    = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b0;
      step(1);
      test_reset();
      test_good_frame();
      test_start_glitch();
      test_bad_stop();
      test_overrun();
      test_reset_midframe();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
